// File: rtl/clk_div_sequencer_if.sv
// Bundle for clk_div_sequencer: requester handshake plus divided-clock outputs.
// The clamped flag exists only when CLK_DIV_SEQ_CLAMP_EN is defined.
interface clk_div_sequencer_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DIV_W   = 33
);
  logic                     run;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*DIV_W-1:0] req_div;
  logic [NUM_REQ-1:0]       ack;
  logic                     busy;
  logic [DIV_W-1:0]         cur_div;
  logic                     upd_done;
  logic                     clock_out;
`ifdef CLK_DIV_SEQ_CLAMP_EN
  logic                     clamped;

  modport master (
    output run, req, req_div,
    input  ack, busy, cur_div, upd_done, clock_out, clamped
  );
  modport slave (
    input  run, req, req_div,
    output ack, busy, cur_div, upd_done, clock_out, clamped
  );
`else
  modport master (
    output run, req, req_div,
    input  ack, busy, cur_div, upd_done, clock_out
  );
  modport slave (
    input  run, req, req_div,
    output ack, busy, cur_div, upd_done, clock_out
  );
`endif
endinterface

// File: rtl/clk_div_sequencer.sv
// Divided-clock generator whose divisor is shared by round-robin requesters and
// swapped only at full-period boundaries. Optional floor clamp: CLK_DIV_SEQ_CLAMP_EN.
module clk_div_sequencer #(
  parameter int unsigned      NUM_REQ     = 4,
  parameter int unsigned      DIV_W       = 33,
  parameter logic [DIV_W-1:0] DEFAULT_DIV = DIV_W'(3),
  parameter logic [DIV_W-1:0] MIN_DIV     = DIV_W'(1)
) (
  input logic                 src_clk,
  input logic                 reset,
  clk_div_sequencer_if.slave  bus
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  typedef logic [IdxW-1:0] idx_t;

`ifdef CLK_DIV_SEQ_CLAMP_EN
  localparam logic [DIV_W-1:0] ResetDiv = (DEFAULT_DIV < MIN_DIV) ? MIN_DIV : DEFAULT_DIV;
`else
  localparam logic [DIV_W-1:0] ResetDiv = DEFAULT_DIV;
  logic unused_min_div;
  assign unused_min_div = ^MIN_DIV;
`endif

  typedef enum logic [0:0] {StIdle, StWaitEdge} state_e;

  state_e             state_q;
  logic [DIV_W-1:0]   counter_q;
  logic               clock_q;
  logic [DIV_W-1:0]   cur_div_q;
  logic [DIV_W-1:0]   pending_q;
  idx_t               ptr_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               busy_q;
  logic               upd_q;

  logic               tc;
  logic               apply;
  logic               grant_valid;
  idx_t               grant_idx;
  int unsigned        best_dist;
  logic [DIV_W-1:0]   div_sel;
  logic [DIV_W-1:0]   lat_div;

  // Distance of requester j from the slot after the pointer, modulo NUM_REQ.
  function automatic int unsigned rr_dist(int unsigned j, idx_t p);
    return (j + NUM_REQ - 32'(p) - 1) % NUM_REQ;
  endfunction

  assign tc    = (counter_q == cur_div_q);
  assign apply = !bus.run || (tc && clock_q);

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = ptr_q;
    best_dist   = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (bus.req[j] && (!grant_valid || rr_dist(j, ptr_q) < best_dist)) begin
        grant_valid = 1'b1;
        grant_idx   = idx_t'(j);
        best_dist   = rr_dist(j, ptr_q);
      end
    end
  end

  always_comb begin
    div_sel = '0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (idx_t'(j) == grant_idx) div_sel = bus.req_div[j*DIV_W +: DIV_W];
    end
  end

`ifdef CLK_DIV_SEQ_CLAMP_EN
  logic need_clamp;
  logic clamped_q;
  assign need_clamp  = (div_sel < MIN_DIV);
  assign lat_div     = need_clamp ? MIN_DIV : div_sel;
  assign bus.clamped = clamped_q;

  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      clamped_q <= 1'b0;
    end else begin
      clamped_q <= (state_q == StIdle) && grant_valid && need_clamp;
    end
  end
`else
  assign lat_div = div_sel;
`endif

  always_ff @(posedge src_clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      counter_q <= '0;
      clock_q   <= 1'b0;
      cur_div_q <= ResetDiv;
      pending_q <= '0;
      ptr_q     <= idx_t'(NUM_REQ - 1);
      ack_q     <= '0;
      busy_q    <= 1'b0;
      upd_q     <= 1'b0;
    end else begin
      ack_q <= '0;
      upd_q <= 1'b0;

      if (!bus.run) begin
        counter_q <= '0;
        clock_q   <= 1'b0;
      end else if (tc) begin
        counter_q <= '0;
        clock_q   <= ~clock_q;
      end else begin
        counter_q <= counter_q + DIV_W'(1);
      end

      case (state_q)
        StIdle: begin
          if (grant_valid) begin
            pending_q        <= lat_div;
            ptr_q            <= grant_idx;
            ack_q[grant_idx] <= 1'b1;
            busy_q           <= 1'b1;
            state_q          <= StWaitEdge;
          end
        end
        StWaitEdge: begin
          // Apply lands where the high phase ends, so the new divisor starts a low phase.
          if (apply) begin
            cur_div_q <= pending_q;
            counter_q <= '0;
            busy_q    <= 1'b0;
            upd_q     <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.busy      = busy_q;
  assign bus.cur_div   = cur_div_q;
  assign bus.upd_done  = upd_q;
  assign bus.clock_out = clock_q;

endmodule
